// File: rtl/data_mem_responder.sv
// data_mem_responder: word RAM slave answering LSU requests a fixed READ_LATENCY after grant; define DATA_MEM_STALL_INJECT_EN for LFSR grant stalls
module data_mem_responder #(
  parameter int DATA_ADDR_WIDTH = 32,
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int READ_LATENCY = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       data_mem_req,
  output logic                       data_mem_gnt,
  input  logic [DATA_ADDR_WIDTH-1:0] data_mem_addr,
  input  logic                       data_mem_we,
  input  logic [3:0]                 data_mem_be,
  input  logic [31:0]                data_mem_wdata,
  output logic                       data_mem_rvalid,
  output logic [31:0]                data_mem_rdata,
  output logic                       data_mem_err
);
  localparam int AW = $clog2(MEM_DEPTH_WORDS);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  typedef enum logic {INIT, READY} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [OW-1:0] out_q, out_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d, err_q, err_d;
  logic [READ_LATENCY-1:0][31:0] dat_q, dat_d;
  logic [31:0] mem_q [MEM_DEPTH_WORDS];
  logic stall, accept, retire, oor, mem_we;
  logic [AW-1:0] idx, mem_idx;
  logic [3:0] mem_be;
  logic [31:0] mem_wdata;
`ifdef DATA_MEM_STALL_INJECT_EN
  logic [15:0] lfsr_q, lfsr_d;
  // Fibonacci LFSR (taps 16,14,13,11) advancing only while in service
  always_comb lfsr_d = state_q == READY ? {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]} : lfsr_q;
  // LFSR register, reseeded on reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_q <= 16'hACE1;
    else lfsr_q <= lfsr_d;
  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif
  assign idx             = data_mem_addr[AW+1:2];
  assign oor             = |(data_mem_addr >> (AW + 2));
  assign retire          = data_mem_rvalid;
  assign data_mem_gnt    = data_mem_req && state_q == READY && (out_q - OW'(retire)) < OW'(MAX_OUTSTANDING) && !stall;
  assign accept          = data_mem_gnt;
  assign data_mem_rvalid = vld_q[READ_LATENCY-1];
  assign data_mem_rdata  = dat_q[READ_LATENCY-1];
  assign data_mem_err    = err_q[READ_LATENCY-1];
  // RAM port: sweeps zeros during INIT, then takes in-range accepted writes
  always_comb begin
    mem_we    = state_q == INIT || (accept && data_mem_we && !oor);
    mem_idx   = state_q == INIT ? ptr_q : idx;
    mem_be    = state_q == INIT ? 4'hF : data_mem_be;
    mem_wdata = state_q == INIT ? 32'h0 : data_mem_wdata;
  end
  // byte-enabled RAM write; contents are defined by the INIT sweep, not by reset
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (mem_we && mem_be[i]) mem_q[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
  // next state: clear sweep, outstanding count and response shift pipe
  always_comb begin
    state_d = (state_q == INIT && ptr_q == AW'(MEM_DEPTH_WORDS - 1)) ? READY : state_q;
    ptr_d   = state_q == INIT ? ptr_q + AW'(1) : ptr_q;
    out_d   = out_q + OW'(accept) - OW'(retire);
    vld_d   = vld_q;
    err_d   = err_q;
    dat_d   = dat_q;
    vld_d[0] = accept;
    err_d[0] = accept && oor;
    dat_d[0] = (accept && !data_mem_we && !oor) ? mem_q[idx] : 32'h0;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      err_d[i] = err_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end
  // state registers; reset drops every in-flight response
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= INIT;
      ptr_q   <= '0;
      out_q   <= '0;
      vld_q   <= '0;
      err_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: random + directed check of data_mem_responder against a cycle-indexed queue model
module tb_data_mem_responder;
  localparam int DEPTH = 16, L = 3, MAX = 2;
  logic clk = 0;
  logic rst_n;
  logic data_mem_req, data_mem_gnt, data_mem_we, data_mem_rvalid, data_mem_err;
  logic [31:0] data_mem_addr, data_mem_wdata, data_mem_rdata;
  logic [3:0] data_mem_be;
  int checks = 0, errors = 0;

  data_mem_responder #(.DATA_ADDR_WIDTH(32), .MEM_DEPTH_WORDS(DEPTH), .READ_LATENCY(L), .MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .rst_n(rst_n), .data_mem_req(data_mem_req), .data_mem_gnt(data_mem_gnt),
    .data_mem_addr(data_mem_addr), .data_mem_we(data_mem_we), .data_mem_be(data_mem_be),
    .data_mem_wdata(data_mem_wdata), .data_mem_rvalid(data_mem_rvalid),
    .data_mem_rdata(data_mem_rdata), .data_mem_err(data_mem_err));

  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] d; logic e; } rsp_t;
  rsp_t q[$];
  logic [31:0] mref [DEPTH];
  int now;
  bit acc;
`ifdef DATA_MEM_STALL_INJECT_EN
  logic [15:0] lfsr;
`endif

  function automatic bit gnt_ref();
    int busy;
    bit stall;
    busy = q.size() - ((q.size() > 0 && q[0].due == now) ? 1 : 0);
`ifdef DATA_MEM_STALL_INJECT_EN
    stall = lfsr[0];
`else
    stall = 0;
`endif
    return rst_n && data_mem_req && now >= DEPTH && busy < MAX && !stall;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      now = 0;
      q.delete();
      acc = 0;
      foreach (mref[i]) mref[i] = 0;
`ifdef DATA_MEM_STALL_INJECT_EN
      lfsr = 16'hACE1;
`endif
    end else begin
      bit g, o;
      int w;
      rsp_t r;
      g = gnt_ref();
      if (q.size() > 0 && q[0].due == now) void'(q.pop_front());
      if (g) begin
        o = data_mem_addr >= 32'(DEPTH * 4);
        w = int'((data_mem_addr >> 2) % DEPTH);
        r.due = now + L;
        r.e = o;
        r.d = (data_mem_we || o) ? 32'h0 : mref[w];
        q.push_back(r);
        if (data_mem_we && !o)
          for (int b = 0; b < 4; b++) if (data_mem_be[b]) mref[w][8*b +: 8] = data_mem_wdata[8*b +: 8];
      end
      acc = g;
`ifdef DATA_MEM_STALL_INJECT_EN
      if (now >= DEPTH) begin
        int fb;
        fb = (lfsr ^ (lfsr >> 2) ^ (lfsr >> 3) ^ (lfsr >> 5)) & 1;
        lfsr = (lfsr >> 1) | 16'(fb << 15);
      end
`endif
      now++;
    end
  end

  always @(negedge clk) begin
    logic [34:0] a, e;
    bit rv;
    a = {data_mem_gnt, data_mem_rvalid, data_mem_err, data_mem_rdata};
    if (!rst_n) e = '0;
    else begin
      rv = q.size() > 0 && q[0].due == now;
      e = {gnt_ref(), rv, rv ? q[0].e : 1'b0, rv ? q[0].d : 32'h0};
    end
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t {gnt,rvalid,err,rdata} got=%h exp=%h", $time, a, e);
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask

  task automatic xact(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    data_mem_req = 1; data_mem_we = we; data_mem_addr = a; data_mem_be = be; data_mem_wdata = wd;
    n = 0;
    @(negedge clk);
    while (!data_mem_gnt && n < 100) begin n++; @(negedge clk); end
    chk("xact_gnt_timeout", 32'(data_mem_gnt), 32'd1);
    @(posedge clk); #1;
    data_mem_req = 0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!data_mem_rvalid && lat < 20);
    rd = data_mem_rdata;
    er = data_mem_err;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    int lat, n;
    rst_n = 0; data_mem_req = 0; data_mem_we = 0; data_mem_addr = 0; data_mem_be = 0; data_mem_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    data_mem_req = 1; data_mem_addr = 32'h3C; rst_n = 1;
`ifndef DATA_MEM_STALL_INJECT_EN
    for (int k = 0; k <= DEPTH; k++) begin
      @(negedge clk);
      chk($sformatf("init_gnt_c%0d", k), 32'(data_mem_gnt), 32'(k == DEPTH));
    end
`endif
    @(posedge clk); #1;
    data_mem_req = 0;
    repeat (L + 1) @(posedge clk);
    #1;
    xact(0, 32'h3C, 4'h0, 32'h0, rd, er, lat);
    chk("init_rdata", rd, 32'h0); chk("init_err", 32'(er), 32'd0);
    xact(1, 32'h10, 4'hF, 32'hDEADBEEF, rd, er, lat);
    chk("wr_rdata", rd, 32'h0);
    xact(1, 32'h10, 4'b0010, 32'h0000AA00, rd, er, lat);
    xact(0, 32'h10, 4'h0, 32'h0, rd, er, lat);
    chk("rw_rdata", rd, 32'hDEADAAEF); chk("rw_lat", 32'(lat), 32'(L));
    xact(1, 32'h40, 4'hF, 32'hFFFFFFFF, rd, er, lat);
    chk("oor_wr_err", 32'(er), 32'd1); chk("oor_wr_rdata", rd, 32'h0);
    xact(0, 32'h1000, 4'h0, 32'h0, rd, er, lat);
    chk("oor_rd_err", 32'(er), 32'd1); chk("oor_rd_rdata", rd, 32'h0);
    xact(0, 32'h0, 4'h0, 32'h0, rd, er, lat);
    chk("oor_alias_rdata", rd, 32'h0); chk("oor_alias_err", 32'(er), 32'd0);
`ifndef DATA_MEM_STALL_INJECT_EN
    data_mem_req = 1; data_mem_we = 0; data_mem_addr = 32'h10;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk($sformatf("thr_gnt_c%0d", k), 32'(data_mem_gnt), 32'(k % 3 != 2));
    end
    @(posedge clk); #1;
    data_mem_req = 0;
    repeat (6) @(posedge clk);
    #1;
`endif
    data_mem_req = 1; data_mem_we = 0; data_mem_addr = 32'h10;
    n = 0;
    for (int k = 0; k < 60 && n < 2; k++) begin
      @(negedge clk);
      if (data_mem_gnt) n++;
    end
    chk("mid_two_grants", 32'(n), 32'd2);
    @(posedge clk); #1;
    rst_n = 0; data_mem_req = 0;
    #1;
    chk("rst_outputs", {29'h0, data_mem_gnt, data_mem_rvalid, data_mem_err}, 32'h0);
    chk("rst_rdata", data_mem_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    n = 0;
    repeat (DEPTH + 8) begin @(negedge clk); n += int'(data_mem_rvalid); end
    chk("rst_no_rvalid", 32'(n), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 3000; i++) begin
      if (!data_mem_req || acc) begin
        int s;
        s = $urandom_range(0, 9);
        data_mem_req = $urandom_range(0, 3) != 0;
        data_mem_we = $urandom_range(0, 1) == 1;
        data_mem_be = 4'($urandom);
        data_mem_wdata = $urandom;
        data_mem_addr = s < 8 ? 32'($urandom_range(0, DEPTH * 4 - 1)) : s == 8 ? 32'($urandom_range(DEPTH * 4, DEPTH * 16)) : $urandom;
      end
      @(posedge clk); #1;
    end
    data_mem_req = 0;
    repeat (L + 4) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
